// File: rtl/async_fifo_cdc.sv
// rtl/async_fifo_cdc.sv - dual-clock first-word-fall-through byte FIFO, Gray pointers across domains
module async_fifo_cdc #(
  parameter int ASIZE = 4,
  parameter int DSIZE = 8
) (
  input  logic             reset_i,
  input  logic             byte_clk_i,
  input  logic             wr_clk_i,
  input  logic             wr_en_i,
  input  logic [DSIZE-1:0] wr_data_i,
  output logic             wr_afull_o,
  output logic             wr_full_o,
  input  logic             rd_en_i,
  output logic [DSIZE-1:0] rd_data_o,
  output logic             rd_empty_o
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] AFULL_LVL = (ASIZE + 1)'(DEPTH - 1);

  function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
    logic [ASIZE:0] b;
    b[ASIZE] = g[ASIZE];
    for (int i = ASIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Reset asserts at once in both domains and releases on each domain's own clock.
  logic [1:0] wr_rst_q, wr_rst_d;
  logic [1:0] rd_rst_q, rd_rst_d;
  logic       wr_rst, rd_rst;

  always_comb begin
    wr_rst_d = {wr_rst_q[0], 1'b0};
    rd_rst_d = {rd_rst_q[0], 1'b0};
  end

  always_ff @(posedge wr_clk_i or posedge reset_i) begin
    if (reset_i) wr_rst_q <= 2'b11;
    else         wr_rst_q <= wr_rst_d;
  end

  always_ff @(posedge byte_clk_i or posedge reset_i) begin
    if (reset_i) rd_rst_q <= 2'b11;
    else         rd_rst_q <= rd_rst_d;
  end

  assign wr_rst = wr_rst_q[1];
  assign rd_rst = rd_rst_q[1];

  logic [DSIZE-1:0] mem [DEPTH];

  // Write domain
  logic [ASIZE:0] wbin_q, wbin_d;
  logic [ASIZE:0] wgray_q, wgray_d;
  logic [ASIZE:0] wq1_rgray_q, wq1_rgray_d;
  logic [ASIZE:0] wq2_rgray_q, wq2_rgray_d;
  logic           wr_full_q, wr_full_d;
  logic           wr_afull_q, wr_afull_d;
  logic           wr_push;

  // Read domain
  logic [ASIZE:0] rbin_q, rbin_d;
  logic [ASIZE:0] rgray_q, rgray_d;
  logic [ASIZE:0] rq1_wgray_q, rq1_wgray_d;
  logic [ASIZE:0] rq2_wgray_q, rq2_wgray_d;
  logic           rd_empty_q, rd_empty_d;
  logic           rd_pop;

  always_comb begin
    wr_push     = wr_en_i && !wr_full_q;
    wbin_d      = wbin_q + {{ASIZE{1'b0}}, wr_push};
    wgray_d     = (wbin_d >> 1) ^ wbin_d;
    wq1_rgray_d = rgray_q;
    wq2_rgray_d = wq1_rgray_q;
    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    wr_full_d   = (wgray_d == {~wq2_rgray_q[ASIZE:ASIZE-1], wq2_rgray_q[ASIZE-2:0]});
    wr_afull_d  = ((wbin_d - gray2bin(wq2_rgray_q)) >= AFULL_LVL);
  end

  always_ff @(posedge wr_clk_i or posedge wr_rst) begin
    if (wr_rst) begin
      wbin_q      <= '0;
      wgray_q     <= '0;
      wq1_rgray_q <= '0;
      wq2_rgray_q <= '0;
      wr_full_q   <= 1'b0;
      wr_afull_q  <= 1'b0;
    end else begin
      wbin_q      <= wbin_d;
      wgray_q     <= wgray_d;
      wq1_rgray_q <= wq1_rgray_d;
      wq2_rgray_q <= wq2_rgray_d;
      wr_full_q   <= wr_full_d;
      wr_afull_q  <= wr_afull_d;
    end
  end

  always_ff @(posedge wr_clk_i) begin
    if (wr_push && !wr_rst) mem[wbin_q[ASIZE-1:0]] <= wr_data_i;
  end

  always_comb begin
    rd_pop      = rd_en_i && !rd_empty_q;
    rbin_d      = rbin_q + {{ASIZE{1'b0}}, rd_pop};
    rgray_d     = (rbin_d >> 1) ^ rbin_d;
    rq1_wgray_d = wgray_q;
    rq2_wgray_d = rq1_wgray_q;
    rd_empty_d  = (rgray_d == rq2_wgray_q);
  end

  always_ff @(posedge byte_clk_i or posedge rd_rst) begin
    if (rd_rst) begin
      rbin_q      <= '0;
      rgray_q     <= '0;
      rq1_wgray_q <= '0;
      rq2_wgray_q <= '0;
      rd_empty_q  <= 1'b1;
    end else begin
      rbin_q      <= rbin_d;
      rgray_q     <= rgray_d;
      rq1_wgray_q <= rq1_wgray_d;
      rq2_wgray_q <= rq2_wgray_d;
      rd_empty_q  <= rd_empty_d;
    end
  end

  assign rd_data_o  = mem[rbin_q[ASIZE-1:0]];
  assign rd_empty_o = rd_empty_q;
  assign wr_full_o  = wr_full_q;
  assign wr_afull_o = wr_afull_q;

endmodule

// File: tb/tb_async_fifo_cdc.sv
// tb/tb_async_fifo_cdc.sv - directed vector bench for async_fifo_cdc
`timescale 1ns/1ps
module tb_async_fifo_cdc;

  logic       reset_i;
  logic       byte_clk_i;
  logic       wr_clk_i;
  logic       wr_en_i;
  logic [7:0] wr_data_i;
  logic       wr_afull_o;
  logic       wr_full_o;
  logic       rd_en_i;
  logic [7:0] rd_data_o;
  logic       rd_empty_o;

  int checks = 0;
  int errors = 0;

  async_fifo_cdc #(.ASIZE(4), .DSIZE(8)) dut (
    .reset_i    (reset_i),
    .byte_clk_i (byte_clk_i),
    .wr_clk_i   (wr_clk_i),
    .wr_en_i    (wr_en_i),
    .wr_data_i  (wr_data_i),
    .wr_afull_o (wr_afull_o),
    .wr_full_o  (wr_full_o),
    .rd_en_i    (rd_en_i),
    .rd_data_o  (rd_data_o),
    .rd_empty_o (rd_empty_o)
  );

  // 60 MHz write clock, 11.289 MHz read clock
  initial wr_clk_i = 1'b0;
  always #8.333 wr_clk_i = ~wr_clk_i;
  initial byte_clk_i = 1'b0;
  always #44.291 byte_clk_i = ~byte_clk_i;

  typedef struct {
    logic       is_pop;
    logic [7:0] data;
    logic       exp_empty;
    logic       exp_afull;
    logic       exp_full;
    logic       chk_data;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[32];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] d);
    @(negedge wr_clk_i);
    wr_en_i   = 1'b1;
    wr_data_i = d;
    @(negedge wr_clk_i);
    wr_en_i   = 1'b0;
  endtask

  task automatic do_pop();
    @(negedge byte_clk_i);
    rd_en_i = 1'b1;
    @(negedge byte_clk_i);
    rd_en_i = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(posedge byte_clk_i);
    @(negedge byte_clk_i);
  endtask

  task automatic run_vectors(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (vecs[i].is_pop) do_pop();
      else                do_write(vecs[i].data);
      settle();
      check($sformatf("vec%0d empty", i), {7'b0, rd_empty_o}, {7'b0, vecs[i].exp_empty});
      check($sformatf("vec%0d afull", i), {7'b0, wr_afull_o}, {7'b0, vecs[i].exp_afull});
      check($sformatf("vec%0d full", i),  {7'b0, wr_full_o},  {7'b0, vecs[i].exp_full});
      if (vecs[i].chk_data)
        check($sformatf("vec%0d data", i), rd_data_o, vecs[i].exp_data);
    end
  endtask

  initial begin
    int n;
    int sent;
    int got;
    // Fill: 16 writes of 0..15, then 8'hFF against a full FIFO; head stays 0.
    for (int i = 0; i < 16; i++) begin
      vecs[i].is_pop    = 1'b0;
      vecs[i].data      = 8'(i);
      vecs[i].exp_empty = 1'b0;
      vecs[i].exp_afull = (i + 1 >= 15);
      vecs[i].exp_full  = (i + 1 == 16);
      vecs[i].chk_data  = 1'b1;
      vecs[i].exp_data  = 8'h00;
    end
    vecs[16].is_pop    = 1'b0;
    vecs[16].data      = 8'hFF;
    vecs[16].exp_empty = 1'b0;
    vecs[16].exp_afull = 1'b1;
    vecs[16].exp_full  = 1'b1;
    vecs[16].chk_data  = 1'b1;
    vecs[16].exp_data  = 8'h00;
    // Drain pops 2..16; after pop k the head is byte k.
    for (int k = 2; k <= 16; k++) begin
      vecs[15 + k].is_pop    = 1'b1;
      vecs[15 + k].data      = 8'h00;
      vecs[15 + k].exp_empty = (k == 16);
      vecs[15 + k].exp_afull = 1'b0;
      vecs[15 + k].exp_full  = 1'b0;
      vecs[15 + k].chk_data  = (k != 16);
      vecs[15 + k].exp_data  = 8'(k);
    end

    reset_i   = 1'b1;
    wr_en_i   = 1'b0;
    wr_data_i = 8'h00;
    rd_en_i   = 1'b0;
    #200;
    check("reset empty", {7'b0, rd_empty_o}, 8'h01);
    check("reset full",  {7'b0, wr_full_o},  8'h00);
    check("reset afull", {7'b0, wr_afull_o}, 8'h00);
    reset_i = 1'b0;
    repeat (4) @(posedge byte_clk_i);

    // Pop while empty must not move the read pointer.
    do_pop();
    settle();
    check("pop on empty", {7'b0, rd_empty_o}, 8'h01);

    // Single byte: visible within 3 read edges, gone on the popping edge.
    @(negedge wr_clk_i);
    wr_en_i   = 1'b1;
    wr_data_i = 8'hA5;
    @(posedge wr_clk_i);
    #1 wr_en_i = 1'b0;
    n = 0;
    while (n < 3 && rd_empty_o) begin
      @(posedge byte_clk_i);
      #1 n++;
    end
    check("single empty clr", {7'b0, rd_empty_o}, 8'h00);
    check("single data", rd_data_o, 8'hA5);
    @(negedge byte_clk_i);
    rd_en_i = 1'b1;
    @(posedge byte_clk_i);
    #1 rd_en_i = 1'b0;
    check("single empty on pop", {7'b0, rd_empty_o}, 8'h01);
    settle();

    run_vectors(0, 16);

    // First pop from full: wr_full_o clears within 3 write edges.
    @(negedge byte_clk_i);
    rd_en_i = 1'b1;
    @(posedge byte_clk_i);
    #1 rd_en_i = 1'b0;
    n = 0;
    while (n < 3 && wr_full_o) begin
      @(posedge wr_clk_i);
      #1 n++;
    end
    check("full clr latency", {7'b0, wr_full_o}, 8'h00);
    settle();
    check("after pop1 afull", {7'b0, wr_afull_o}, 8'h01);
    check("after pop1 data", rd_data_o, 8'h01);

    run_vectors(17, 31);

    // Mid-stream reset with 7 entries stored.
    for (int i = 0; i < 7; i++) do_write(8'(8'h40 + i));
    settle();
    check("pre-reset empty", {7'b0, rd_empty_o}, 8'h00);
    check("pre-reset data", rd_data_o, 8'h40);
    @(negedge wr_clk_i);
    reset_i = 1'b1;
    #1;
    check("midrst empty", {7'b0, rd_empty_o}, 8'h01);
    check("midrst full",  {7'b0, wr_full_o},  8'h00);
    check("midrst afull", {7'b0, wr_afull_o}, 8'h00);
    #30 reset_i = 1'b0;
    repeat (4) @(posedge byte_clk_i);
    do_write(8'h3C);
    settle();
    check("post-reset empty", {7'b0, rd_empty_o}, 8'h00);
    check("post-reset data", rd_data_o, 8'h3C);
    do_pop();
    settle();
    check("post-reset drained", {7'b0, rd_empty_o}, 8'h01);

    // Streaming 1000 incrementing bytes, writer throttled by almost-full.
    sent = 0;
    got  = 0;
    fork
      begin
        int wc = 0;
        while (sent < 1000 && wc < 30000) begin
          @(negedge wr_clk_i);
          wc++;
          if (!wr_afull_o) begin
            wr_en_i   = 1'b1;
            wr_data_i = 8'(sent);
            sent++;
          end else begin
            wr_en_i = 1'b0;
          end
        end
        @(negedge wr_clk_i);
        wr_en_i = 1'b0;
      end
      begin
        int rc = 0;
        while (got < 1000 && rc < 5000) begin
          @(negedge byte_clk_i);
          rc++;
          if (!rd_empty_o) begin
            check("stream data", rd_data_o, 8'(got));
            rd_en_i = 1'b1;
            got++;
          end else begin
            rd_en_i = 1'b0;
          end
        end
        @(negedge byte_clk_i);
        rd_en_i = 1'b0;
      end
    join
    checks++;
    if (sent != 1000) begin
      errors++;
      $display("FAIL stream sent got %0d expected 1000", sent);
    end
    checks++;
    if (got != 1000) begin
      errors++;
      $display("FAIL stream received got %0d expected 1000", got);
    end
    settle();
    check("stream final empty", {7'b0, rd_empty_o}, 8'h01);
    check("stream final full",  {7'b0, wr_full_o},  8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
